key_scan: RTL and testbench

Scanner for a 4×4 matrix keypad, used to set the RTC time and date. It is the input-side counterpart of the multiplexed seven-segment display driver:
- rotates an active-low one-hot row strobe;
- samples the active-low column lines and debounces the full 16-key map;
- reports single key presses as hex codes;
- assembles decimal digits into a 24-bit BCD entry word.

The entry word has the same six-nibble layout as the display data bus (nibble 0 = rightmost digit), so it can be shown while it is being typed and committed to the RTC counters.

---
 rtl/key_scan_pkg.sv | 31 +++
 rtl/key_scan_if.sv | 19 +
 rtl/key_map_debounce.sv | 38 +++
 rtl/key_scan.sv | 108 ++++++++++
 tb/tb_key_scan.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/key_scan_pkg.sv
// Shared constants, FSM state type and key-map helpers for the 4x4 keypad scanner.
package key_scan_pkg;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_COMMIT = 4'hB;
    localparam logic [3:0] ROW_RESET  = 4'b1110;

    typedef enum logic {IDLE, HELD} key_state_e;

    function automatic logic [4:0] key_count(input logic [15:0] map);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, map[i]};
        end
        return n;
    endfunction

    // Only meaningful when exactly one bit of map is set.
    function automatic logic [3:0] key_index(input logic [15:0] map);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (map[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_scan_if.sv
// Keypad pins plus key report / BCD entry outputs of the keypad scanner.
interface key_scan_if;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [23:0] entry;
    logic        commit;

    modport master (
        input  col_n,
        output row_n, key_valid, key_code, entry, commit
    );

    modport slave (
        output col_n,
        input  row_n, key_valid, key_code, entry, commit
    );
endinterface

// File: rtl/key_map_debounce.sv
// Accepts a new 16-key map only after it has been seen in DEBOUNCE_FRAMES consecutive frames.
module key_map_debounce #(
    parameter int unsigned DEBOUNCE_FRAMES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_done,
    input  logic [15:0] frame_map,
    output logic [15:0] deb_map
);

    localparam logic [7:0] STABLE_MAX = 8'(DEBOUNCE_FRAMES - 1);

    logic [15:0] prev_map;
    logic [7:0]  stable_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_map   <= 16'd0;
            stable_cnt <= 8'd0;
            deb_map    <= 16'd0;
        end else if (frame_done) begin
            prev_map <= frame_map;
            if (frame_map == prev_map) begin
                // Saturation keeps a long-stable map from being reloaded.
                if (stable_cnt != STABLE_MAX) begin
                    stable_cnt <= stable_cnt + 8'd1;
                    if (stable_cnt + 8'd1 == STABLE_MAX) begin
                        deb_map <= frame_map;
                    end
                end
            end else begin
                stable_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: row strobe, debounced key map, single-key reports and BCD entry word.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int unsigned SCAN_CNT_MAX    = 1000,
    parameter int unsigned DEBOUNCE_FRAMES = 20
) (
    input logic        clk,
    input logic        rst,
    key_scan_if.master bus
);

    localparam logic [9:0] CNT_LAST = 10'(SCAN_CNT_MAX - 1);

    logic [3:0]  col_meta;
    logic [3:0]  col_sync;
    logic [9:0]  cnt;
    logic [1:0]  row;
    logic [15:0] raw_map;
    logic [15:0] frame_map;
    logic [15:0] deb_map;
    logic        sample;
    logic        frame_done;
    logic [4:0]  n_keys;
    logic [3:0]  idx;
    key_state_e  state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= 4'b1111;
            col_sync <= 4'b1111;
        end else begin
            col_meta <= bus.col_n;
            col_sync <= col_meta;
        end
    end

    assign sample     = (cnt == CNT_LAST);
    assign frame_done = sample && (row == 2'd3);
    // Row 3 lands in raw_map one cycle late, so splice the live sample in.
    assign frame_map  = {~col_sync, raw_map[11:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= 10'd0;
            row        <= 2'd0;
            raw_map    <= 16'd0;
            bus.row_n  <= ROW_RESET;
        end else if (sample) begin
            cnt                         <= 10'd0;
            raw_map[{row, 2'b00} +: 4]  <= ~col_sync;
            bus.row_n                   <= {bus.row_n[2:0], bus.row_n[3]};
            row                         <= row + 2'd1;
        end else begin
            cnt <= cnt + 10'd1;
        end
    end

    key_map_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .frame_done(frame_done),
        .frame_map (frame_map),
        .deb_map   (deb_map)
    );

    assign n_keys = key_count(deb_map);
    assign idx    = key_index(deb_map);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.key_valid <= 1'b0;
            bus.key_code  <= 4'd0;
            bus.entry     <= 24'd0;
            bus.commit    <= 1'b0;
        end else begin
            bus.key_valid <= 1'b0;
            bus.commit    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (n_keys == 5'd1) begin
                        bus.key_valid <= 1'b1;
                        bus.key_code  <= idx;
                        state         <= HELD;
                        if (idx <= 4'd9) begin
                            bus.entry <= {bus.entry[19:0], idx};
                        end else if (idx == KEY_CLEAR) begin
                            bus.entry <= 24'd0;
                        end else if (idx == KEY_COMMIT) begin
                            bus.commit <= 1'b1;
                        end
                    end
                end
                HELD: begin
                    // No rollover: only a fully released keypad re-arms.
                    if (deb_map == 16'd0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: keypad model, frame-level reference model and directed key sequences.
module tb_key_scan;

    localparam int SCAN  = 4;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * SCAN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'd0;

    always #5 clk = ~clk;

    key_scan_if kif ();

    key_scan #(
        .SCAN_CNT_MAX   (SCAN),
        .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kif)
    );

    // Pressed key pulls its column low while its row is strobed.
    always_comb begin
        kif.col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!kif.row_n[r] && keys[r*4+c]) kif.col_n[c] = 1'b0;
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] only_key(input logic [15:0] m);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 0; i < 16; i++) if (m[i]) k = 4'(i);
        return k;
    endfunction

    // Reference model: edge count since reset, keys seen two edges before each row sample,
    // a run-length count of identical frames, and a held flag.
    int          e = 0;
    int          r = 0;
    int          run = 1;
    logic [15:0] k1 = 16'd0, k2 = 16'd0, fm = 16'd0, last_map = 16'd0, deb = 16'd0;
    bit          held = 0, pend = 0;
    logic [3:0]  pend_code = 4'd0;
    logic [3:0]  exp_row_n = 4'b1110;
    logic        exp_valid = 1'b0, exp_commit = 1'b0;
    logic [3:0]  exp_code = 4'd0;
    logic [23:0] exp_entry = 24'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = 0; run = 1; k1 = 0; k2 = 0; fm = 0; last_map = 0; deb = 0;
            held = 0; pend = 0;
            exp_row_n = 4'b1110; exp_valid = 0; exp_commit = 0; exp_code = 0; exp_entry = 0;
        end else begin
            e++;
            exp_valid  = 1'b0;
            exp_commit = 1'b0;
            if (pend) begin
                exp_valid = 1'b1;
                exp_code  = pend_code;
                if (pend_code < 4'd10) exp_entry = {exp_entry[19:0], pend_code};
                else if (pend_code == 4'hA) exp_entry = 24'd0;
                else if (pend_code == 4'hB) exp_commit = 1'b1;
                pend = 0;
            end
            if (e % 4 == 0) begin
                r = ((e - 1) / 4) % 4;
                fm[r*4 +: 4] = k2[r*4 +: 4];
                if (r == 3) begin
                    if (fm == last_map) begin
                        if (run <= DEB) run++;
                    end else begin
                        run = 1;
                    end
                    last_map = fm;
                    if (run == DEB) begin
                        deb = fm;
                        if (!held && $countones(deb) == 1) begin
                            pend      = 1;
                            pend_code = only_key(deb);
                            held      = 1;
                        end else if (held && deb == 16'd0) begin
                            held = 0;
                        end
                    end
                end
            end
            k2 = k1;
            k1 = keys;
            exp_row_n = ~(4'b0001 << ((e / 4) % 4));
        end
    end

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("row_n",     {28'd0, kif.row_n},    {28'd0, exp_row_n});
            check("key_valid", {31'd0, kif.key_valid}, {31'd0, exp_valid});
            check("key_code",  {28'd0, kif.key_code}, {28'd0, exp_code});
            check("entry",     {8'd0, kif.entry},     {8'd0, exp_entry});
            check("commit",    {31'd0, kif.commit},   {31'd0, exp_commit});
        end
    end

    int         pulses = 0, commits = 0;
    logic [3:0] last_code = 4'd0, commit_code = 4'd0;

    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            pulses++;
            last_code = kif.key_code;
        end
        if (kif.commit === 1'b1) begin
            commits++;
            commit_code = kif.key_code;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press_release(input int k);
        keys[k] = 1'b1;
        tick(5 * FRAME);
        keys[k] = 1'b0;
        tick(5 * FRAME);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_n"}, {28'd0, kif.row_n}, 32'hE);
        check({tag, "_entry"}, {8'd0, kif.entry}, 32'h0);
        check({tag, "_key_valid"}, {31'd0, kif.key_valid}, 32'h0);
        check({tag, "_commit"}, {31'd0, kif.commit}, 32'h0);
        check({tag, "_key_code"}, {28'd0, kif.key_code}, 32'h0);
    endtask

    int p0, c0;

    initial begin
        tick(3);
        cmp_en = 1;
        check_reset_outputs("reset");

        rst = 1'b0;
        tick(4); check("rot1", {28'd0, kif.row_n}, 32'hD);
        tick(4); check("rot2", {28'd0, kif.row_n}, 32'hB);
        tick(4); check("rot3", {28'd0, kif.row_n}, 32'h7);
        tick(4); check("rot4", {28'd0, kif.row_n}, 32'hE);

        // Clean press of row 2, col 1, then a long hold.
        p0 = pulses;
        keys[9] = 1'b1;
        tick(5 * FRAME);
        check("clean_pulses", 32'(pulses - p0), 32'd1);
        check("clean_code", {28'd0, last_code}, 32'h9);
        check("clean_entry", {8'd0, kif.entry}, 32'h9);
        p0 = pulses;
        tick(20 * FRAME);
        check("held_no_repeat", 32'(pulses - p0), 32'd0);
        keys[9] = 1'b0;
        tick(5 * FRAME);

        press_release(10);
        check("clear_entry", {8'd0, kif.entry}, 32'h0);
        press_release(1);
        press_release(2);
        press_release(0);
        press_release(5);
        check("seq_entry", {8'd0, kif.entry}, 32'h001205);
        c0 = commits;
        press_release(11);
        check("commit_count", 32'(commits - c0), 32'd1);
        check("commit_code", {28'd0, commit_code}, 32'hB);
        check("commit_entry", {8'd0, kif.entry}, 32'h001205);
        press_release(10);
        check("clear_again", {8'd0, kif.entry}, 32'h0);

        // Bounce on key 5, aligned to a frame boundary so no three frames agree.
        for (int i = 0; i < FRAME && (e % FRAME) != 0; i++) tick(1);
        p0 = pulses;
        for (int t = 0; t < 8; t++) begin
            keys[5] = (t % 2 == 0);
            tick(10);
        end
        keys[5] = 1'b0;
        tick(5 * FRAME);
        check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
        p0 = pulses;
        keys[5] = 1'b1;
        tick(5 * FRAME);
        check("stable5_pulses", 32'(pulses - p0), 32'd1);
        check("stable5_code", {28'd0, last_code}, 32'h5);
        keys[5] = 1'b0;
        tick(5 * FRAME);

        // Two keys together, then release one.
        p0 = pulses;
        keys[3] = 1'b1;
        keys[6] = 1'b1;
        tick(5 * FRAME);
        check("multi_no_pulse", 32'(pulses - p0), 32'd0);
        keys[6] = 1'b0;
        tick(5 * FRAME);
        check("multi_release_pulses", 32'(pulses - p0), 32'd1);
        check("multi_release_code", {28'd0, last_code}, 32'h3);
        keys[3] = 1'b0;
        tick(5 * FRAME);

        // Reset while a key is held.
        press_release(10);
        press_release(4);
        keys[2] = 1'b1;
        tick(5 * FRAME);
        check("pre_reset_entry", {8'd0, kif.entry}, 32'h42);
        check("pre_reset_code", {28'd0, last_code}, 32'h2);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("midreset");
        tick(1);
        rst = 1'b0;
        p0 = pulses;
        tick(6 * FRAME);
        check("after_reset_pulses", 32'(pulses - p0), 32'd1);
        check("after_reset_code", {28'd0, last_code}, 32'h2);
        check("after_reset_entry", {8'd0, kif.entry}, 32'h2);
        keys[2] = 1'b0;
        tick(3 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
